rc5_block_encryptor: RTL

//  RC5-w/r block cipher datapath, directly downstream of keyExpander.

---
 rtl/rc5_block_encryptor.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rc5_block_encryptor.sv
// rtl/rc5_block_encryptor.sv - RC5-w/r block cipher datapath fed from an expanded S table
//
// Encrypts one two-word block (A_in, B_in) per accepted start using the
// expanded key table S[0..t-1], which is read one word per cycle via
// S_address / S_sub_i. The table comes from an upstream key expander.
// It is valid while keys_valid is high.
//
// Optional feature: define RC5_DECRYPT_EN to add a 'mode' input.
// mode is sampled with start: 0 = encrypt, 1 = decrypt.
// Decrypt uses the same state sequence and latency and walks the table downwards.
//
// Ports
//   clk1        sole clock, posedge
//   rst         synchronous reset, active-high
//   keys_valid  S table complete and stable; qualifies start
//   start       block request, sampled only while idle
//   mode        (RC5_DECRYPT_EN only) 0 = encrypt, 1 = decrypt
//   A_in, B_in  input block words, latched at start acceptance
//   S_address   S table read address (combinational, 0 when idle or finishing)
//   S_sub_i     S[S_address], combinational read in the same cycle
//   busy        high from start acceptance through the done cycle
//   done        one-cycle pulse, A_out/B_out valid
//   A_out,B_out result words, held until the next done

module rc5_block_encryptor #(
    parameter int w        = 32,
    parameter int r        = 12,
    parameter int t        = 2 * (r + 1),
    parameter int t_length = $clog2(t),
    parameter int rot_bits = $clog2(w)
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic                keys_valid,
    input  logic                start,
`ifdef RC5_DECRYPT_EN
    input  logic                mode,
`endif
    input  logic [w-1:0]        A_in,
    input  logic [w-1:0]        B_in,
    output logic [t_length-1:0] S_address,
    input  logic [w-1:0]        S_sub_i,
    output logic                busy,
    output logic                done,
    output logic [w-1:0]        A_out,
    output logic [w-1:0]        B_out
);

    // i only ever needs to hold 0..r, and {i, 1'b0} is exactly t_length wide.
    localparam int IW = t_length - 1;
    localparam logic [IW-1:0]       I_LAST = IW'(r);
    localparam logic [IW-1:0]       I_ONE  = IW'(1);
    localparam logic [t_length-1:0] T_LAST = t_length'(t - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE_A,
        PRE_B,
        RND_A,
        RND_B,
        FIN
    } state_t;

    state_t        state_q, state_d;
    logic [w-1:0]  a_q, a_d;
    logic [w-1:0]  b_q, b_d;
    logic [IW-1:0] i_q, i_d;
    logic          busy_q, busy_d;
    logic [w-1:0]  a_out_q, a_out_d;
    logic [w-1:0]  b_out_q, b_out_d;
`ifdef RC5_DECRYPT_EN
    logic          mode_q, mode_d;
`endif

    // Rotates via a doubled word so that an amount of 0 returns x unchanged.
    function automatic logic [w-1:0] rotl(input logic [w-1:0] x, input logic [rot_bits-1:0] n);
        logic [2*w-1:0] dbl;
        dbl = {x, x} << n;
        return dbl[2*w-1:w];
    endfunction

`ifdef RC5_DECRYPT_EN
    function automatic logic [w-1:0] rotr(input logic [w-1:0] x, input logic [rot_bits-1:0] n);
        logic [2*w-1:0] dbl;
        dbl = {x, x} >> n;
        return dbl[w-1:0];
    endfunction
`endif

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= '0;
            busy_q  <= 1'b0;
            a_out_q <= '0;
            b_out_q <= '0;
`ifdef RC5_DECRYPT_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
`ifdef RC5_DECRYPT_EN
            mode_q  <= mode_d;
`endif
        end
    end

    // Table address. The step address is the encrypt order 0..t-1.
    // Decrypt mirrors it so the same sequence walks t-1 down to 0.
    logic [t_length-1:0] step_addr;
    logic                addr_en;

    always_comb begin
        step_addr = '0;
        addr_en   = 1'b0;
        case (state_q)
            PRE_A: begin
                step_addr = '0;
                addr_en   = 1'b1;
            end
            PRE_B: begin
                step_addr = t_length'(1);
                addr_en   = 1'b1;
            end
            RND_A: begin
                step_addr = {i_q, 1'b0};
                addr_en   = 1'b1;
            end
            RND_B: begin
                step_addr = {i_q, 1'b1};
                addr_en   = 1'b1;
            end
            default: begin
                step_addr = '0;
                addr_en   = 1'b0;
            end
        endcase

        S_address = '0;
        if (addr_en) begin
`ifdef RC5_DECRYPT_EN
            S_address = mode_q ? (T_LAST - step_addr) : step_addr;
`else
            S_address = step_addr;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        i_d     = i_q;
        busy_d  = busy_q;
        a_out_d = a_out_q;
        b_out_d = b_out_q;
        done    = 1'b0;
`ifdef RC5_DECRYPT_EN
        mode_d  = mode_q;
`endif

        case (state_q)
            IDLE: begin
                if (start && keys_valid) begin
                    a_d     = A_in;
                    b_d     = B_in;
                    busy_d  = 1'b1;
                    state_d = PRE_A;
`ifdef RC5_DECRYPT_EN
                    mode_d  = mode;
`endif
                end
            end

            // In decrypt, the first two steps are the B/A half-rounds for round r.
            PRE_A: begin
`ifdef RC5_DECRYPT_EN
                if (mode_q)
                    b_d = rotr(b_q - S_sub_i, a_q[rot_bits-1:0]) ^ a_q;
                else
`endif
                    a_d = a_q + S_sub_i;
                state_d = PRE_B;
            end

            PRE_B: begin
`ifdef RC5_DECRYPT_EN
                if (mode_q)
                    a_d = rotr(a_q - S_sub_i, b_q[rot_bits-1:0]) ^ b_q;
                else
`endif
                    b_d = b_q + S_sub_i;
                i_d     = I_ONE;
                state_d = RND_A;
            end

            // Decrypt round pass i handles cipher round r-i.
            // The final pass (i == r) removes the S[1]/S[0] whitening.
            RND_A: begin
`ifdef RC5_DECRYPT_EN
                if (mode_q) begin
                    if (i_q == I_LAST)
                        b_d = b_q - S_sub_i;
                    else
                        b_d = rotr(b_q - S_sub_i, a_q[rot_bits-1:0]) ^ a_q;
                end else
`endif
                    a_d = rotl(a_q ^ b_q, b_q[rot_bits-1:0]) + S_sub_i;
                state_d = RND_B;
            end

            RND_B: begin
`ifdef RC5_DECRYPT_EN
                if (mode_q) begin
                    if (i_q == I_LAST)
                        a_d = a_q - S_sub_i;
                    else
                        a_d = rotr(a_q - S_sub_i, b_q[rot_bits-1:0]) ^ b_q;
                end else
`endif
                    b_d = rotl(b_q ^ a_q, a_q[rot_bits-1:0]) + S_sub_i;
                if (i_q == I_LAST) begin
                    // Results are loaded on entry to FIN.
                    // This makes them valid in the same cycle as the done pulse.
                    a_out_d = a_d;
                    b_out_d = b_d;
                    state_d = FIN;
                end else begin
                    i_d     = i_q + I_ONE;
                    state_d = RND_A;
                end
            end

            FIN: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                i_d     = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = busy_q;
    assign A_out = a_out_q;
    assign B_out = b_out_q;

endmodule
